// File: rtl/temp_sensor_arbiter.sv
// temp_sensor_arbiter
//
// Shares the single on-chip temperature sensor ADC between NUM_REQ requesters.
// Each granted request runs one enable/clear/wait-valid sequence. The 8-bit
// reading, or a timeout, is returned to that requester only. Also keeps an
// over-temperature alarm with hysteresis when the TEMP_ARB_ALARM_EN macro is
// defined. With the macro undefined, no alarm logic is built and alarm is 0.
//
// Ports:
//   clk_50mhz    in   only clock
//   reset_n      in   asynchronous active-low reset
//   req          in   level request, one bit per requester
//   rsp_valid    out  one-cycle pulse to the served requester
//   rsp_data     out  8-bit reading, valid while any rsp_valid bit is high
//   rsp_timeout  out  qualifies rsp_valid: no reading arrived
//   busy         out  high in every state except idle
//   temp_valid   in   sensor reading valid
//   temp_val     in   sensor reading
//   temp_en      out  sensor enable
//   temp_clear   out  sensor clear
//   alarm        out  over-temperature flag
module temp_sensor_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned CLEAR_CYCLES   = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter logic [7:0]  ALARM_HI       = 8'd85,
  parameter logic [7:0]  ALARM_LO       = 8'd75
) (
  input  logic               clk_50mhz,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               rsp_timeout,
  output logic               busy,
  input  logic               temp_valid,
  input  logic [7:0]         temp_val,
  output logic               temp_en,
  output logic               temp_clear,
  output logic               alarm
);

  localparam int unsigned CntMax = (CLEAR_CYCLES > TIMEOUT_CYCLES) ? CLEAR_CYCLES
                                                                   : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CntW-1:0] ClearLast   = CntW'(CLEAR_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx     = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StClear, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              busy_q, busy_d;
  logic              temp_en_q, temp_en_d;
  logic              temp_clear_q, temp_clear_d;
  logic              timeout_hit;

  logic              rr_found;
  logic [IdxW-1:0]   rr_idx;

  // Round-robin search: first pass from the pointer upwards, second pass
  // covers the indices below the pointer (the wrap-around).
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!rr_found && (j >= 32'(ptr_q)) && req[j]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!rr_found && (j < 32'(ptr_q)) && req[j]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    timeout_hit = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_idx;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (cnt_q == ClearLast) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWait: begin
        // A valid reading takes priority over a coincident timeout.
        if (temp_valid) begin
          rsp_data_d = temp_val;
          state_d    = StDone;
        end else if (cnt_q == TimeoutLast) begin
          timeout_hit = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        ptr_d   = (grant_q == LastIdx) ? '0 : grant_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the next state.
    temp_en_d     = (state_d == StClear) || (state_d == StWait);
    temp_clear_d  = (state_d != StWait);
    busy_d        = (state_d != StIdle);
    rsp_valid_d   = (state_d == StDone) ? (NUM_REQ'(1) << grant_q) : '0;
    rsp_timeout_d = timeout_hit;
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      temp_en_q     <= 1'b0;
      temp_clear_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      temp_en_q     <= temp_en_d;
      temp_clear_q  <= temp_clear_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign temp_en     = temp_en_q;
  assign temp_clear  = temp_clear_q;

`ifdef TEMP_ARB_ALARM_EN
  logic alarm_q, alarm_d;

  // Only a real reading updates the alarm; timeouts leave it untouched.
  always_comb begin
    alarm_d = alarm_q;
    if ((state_q == StWait) && temp_valid) begin
      if (temp_val >= ALARM_HI) begin
        alarm_d = 1'b1;
      end else if (temp_val <= ALARM_LO) begin
        alarm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_temp_sensor_arbiter.sv
module tb_temp_sensor_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned C = 80;
  localparam int unsigned T = 200;
`ifdef TEMP_ARB_ALARM_EN
  localparam bit AlarmOn = 1'b1;
`else
  localparam bit AlarmOn = 1'b0;
`endif

  logic         clk_50mhz = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic [N-1:0] rsp_valid;
  logic [7:0]   rsp_data;
  logic         rsp_timeout;
  logic         busy;
  logic         temp_valid;
  logic [7:0]   temp_val;
  logic         temp_en;
  logic         temp_clear;
  logic         alarm;

  always #10 clk_50mhz = ~clk_50mhz;

  temp_sensor_arbiter #(
    .NUM_REQ       (N),
    .CLEAR_CYCLES  (C),
    .TIMEOUT_CYCLES(T),
    .ALARM_HI      (8'd85),
    .ALARM_LO      (8'd75)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .reset_n    (reset_n),
    .req        (req),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .temp_valid (temp_valid),
    .temp_val   (temp_val),
    .temp_en    (temp_en),
    .temp_clear (temp_clear),
    .alarm      (alarm)
  );

  typedef struct {
    logic [N+9:0] rsp;  // {rsp_valid, rsp_data, rsp_timeout, alarm}
    int           lat;
    int           idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int         ptr_m     = 0;
  logic [7:0] last_data = 8'h00;
  logic       alarm_m   = 1'b0;

  // Observed response of the last transaction
  logic [N-1:0] got_v;
  logic [7:0]   got_d;
  logic         got_to;
  logic         got_al;
  logic         got_en;
  int           got_lat;
  int           got_low;
  bit           got_done;

  task automatic push_exp(input logic [N-1:0] r, input int delay, input logic [7:0] v);
    exp_t e;
    int   g;
    bit   to;
    g = -1;
    for (int i = 0; i < int'(N); i++) begin
      int c;
      c = (ptr_m + i) % int'(N);
      if (g < 0 && r[c]) g = c;
    end
    to = (delay < 0) || (delay > int'(T) - 1);
    if (!to) begin
      last_data = v;
      if (AlarmOn) begin
        if (v >= 8'd85) alarm_m = 1'b1;
        else if (v <= 8'd75) alarm_m = 1'b0;
      end
    end
    ptr_m = (g + 1) % int'(N);
    e.rsp = {N'(1) << g, last_data, to, alarm_m};
    e.lat = to ? int'(C + T + 1) : int'(C) + 2 + delay;
    e.idx = g;
    sb.push_back(e);
  endtask

  // Drives one request and plays the sensor: temp_valid is raised in the
  // WAIT cycle with index 'delay' (negative: never). Cycle 0 is the cycle in
  // which req is first sampled.
  task automatic do_txn(input logic [N-1:0] r, input int delay, input logic [7:0] v,
                        input bit hold);
    int n;
    int widx;
    n = 0; widx = 0;
    got_low = 0; got_done = 1'b0; got_lat = -1;
    got_v = '0; got_d = '0; got_to = 1'b0; got_al = 1'b0; got_en = 1'b1;
    @(negedge clk_50mhz);
    req = r;
    temp_valid = 1'b0;
    while (n < int'(C + T + 20) && !got_done) begin
      @(negedge clk_50mhz);
      n++;
      temp_valid = 1'b0;
      if (rsp_valid != '0) begin
        got_v = rsp_valid; got_d = rsp_data; got_to = rsp_timeout;
        got_al = alarm; got_en = temp_en; got_lat = n; got_done = 1'b1;
        if (!hold) req = '0;
      end else if (temp_en && !temp_clear) begin
        got_low++;
        if (widx == delay) begin
          temp_valid = 1'b1;
          temp_val   = v;
        end
        widx++;
      end
    end
    temp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; temp_valid = 1'b0; temp_val = 8'h00;
    #35;
    checks++;
    if ({temp_en, temp_clear, busy, rsp_valid, rsp_data, rsp_timeout, alarm} !==
        {1'b0, 1'b1, 1'b0, {N{1'b0}}, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got en=%b clr=%b busy=%b v=%b d=%h to=%b al=%b required 0 1 0 0 00 0 0",
               temp_en, temp_clear, busy, rsp_valid, rsp_data, rsp_timeout, alarm);
    end
    @(negedge clk_50mhz);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    checks++;
    if ({temp_en, temp_clear, busy, rsp_valid} !== {1'b0, 1'b1, 1'b0, {N{1'b0}}}) begin
      errors++;
      $display("FAIL idle_after_reset got en=%b clr=%b busy=%b v=%b required 0 1 0 0",
               temp_en, temp_clear, busy, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    int         grants [4];
    exp_t       e;
    vals = '{8'h10, 8'h20, 8'h30, 8'h40};
    grants = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      push_exp(2'b11, 2, vals[i]);
      do_txn(2'b11, 2, vals[i], i < 3);
      e = sb.pop_front();
      checks++;
      if (!got_done) begin
        errors++;
        $display("FAIL contention_%0d no response within budget", i);
      end else if ({got_v, got_d, got_to, got_al} !== e.rsp || got_lat != e.lat) begin
        errors++;
        $display("FAIL contention_%0d got rsp=%h lat=%0d required rsp=%h lat=%0d",
                 i, {got_v, got_d, got_to, got_al}, got_lat, e.rsp, e.lat);
      end
      checks++;
      if (got_v !== (N'(1) << grants[i]) || got_en !== 1'b0) begin
        errors++;
        $display("FAIL contention_grant_%0d got v=%b en=%b required v=%b en=0",
                 i, got_v, got_en, N'(1) << grants[i]);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    push_exp(2'b01, 5, 8'h2A);
    do_txn(2'b01, 5, 8'h2A, 1'b0);
    e = sb.pop_front();
    checks++;
    if (!got_done || {got_v, got_d, got_to, got_al} !== e.rsp || got_lat != e.lat) begin
      errors++;
      $display("FAIL single got rsp=%h lat=%0d required rsp=%h lat=%0d",
               {got_v, got_d, got_to, got_al}, got_lat, e.rsp, e.lat);
    end
    checks++;
    if (got_low != 6) begin
      errors++;
      $display("FAIL single_clear_low got %0d cycles required 6", got_low);
    end
    @(negedge clk_50mhz);
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL single_pulse_width got rsp_valid=%b after pulse required 0", rsp_valid);
    end
  endtask

  task automatic test_alarm();
    logic [7:0] vals [5];
    logic       want [5];
    exp_t       e;
    vals = '{8'd80, 8'd86, 8'd80, 8'd75, 8'd80};
    want = AlarmOn ? '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0} : '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      push_exp(2'b01, 1, vals[i]);
      do_txn(2'b01, 1, vals[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if (!got_done || {got_v, got_d, got_to, got_al} !== e.rsp) begin
        errors++;
        $display("FAIL alarm_rsp_%0d got rsp=%h required rsp=%h",
                 i, {got_v, got_d, got_to, got_al}, e.rsp);
      end
      checks++;
      if (got_al !== want[i]) begin
        errors++;
        $display("FAIL alarm_seq_%0d got alarm=%b required %b", i, got_al, want[i]);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    push_exp(2'b01, 0, 8'd90);
    do_txn(2'b01, 0, 8'd90, 1'b0);
    e = sb.pop_front();
    checks++;
    if (!got_done || {got_v, got_d, got_to, got_al} !== e.rsp) begin
      errors++;
      $display("FAIL pre_timeout got rsp=%h required rsp=%h", {got_v, got_d, got_to, got_al}, e.rsp);
    end
    push_exp(2'b01, -1, 8'h00);
    do_txn(2'b01, -1, 8'h00, 1'b0);
    e = sb.pop_front();
    checks++;
    if (!got_done || {got_v, got_d, got_to, got_al} !== e.rsp || got_lat != e.lat) begin
      errors++;
      $display("FAIL timeout got rsp=%h lat=%0d required rsp=%h lat=%0d",
               {got_v, got_d, got_to, got_al}, got_lat, e.rsp, e.lat);
    end
  endtask

  task automatic test_coincident();
    exp_t e;
    push_exp(2'b01, int'(T) - 1, 8'h33);
    do_txn(2'b01, int'(T) - 1, 8'h33, 1'b0);
    e = sb.pop_front();
    checks++;
    if (!got_done || {got_v, got_d, got_to, got_al} !== e.rsp || got_lat != e.lat) begin
      errors++;
      $display("FAIL coincident got rsp=%h lat=%0d required rsp=%h lat=%0d",
               {got_v, got_d, got_to, got_al}, got_lat, e.rsp, e.lat);
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    int   n;
    @(negedge clk_50mhz);
    req = 2'b11;
    n = 0;
    while (temp_clear !== 1'b0 && n < int'(C) + 10) begin
      @(negedge clk_50mhz);
      n++;
    end
    checks++;
    if (temp_clear !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_reach_wait got temp_clear=%b required 0", temp_clear);
    end
    repeat (2) @(negedge clk_50mhz);
    reset_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({temp_en, temp_clear, busy, rsp_valid} !== {1'b0, 1'b1, 1'b0, {N{1'b0}}}) begin
      errors++;
      $display("FAIL reset_mid_async got en=%b clr=%b busy=%b v=%b required 0 1 0 0",
               temp_en, temp_clear, busy, rsp_valid);
    end
    @(negedge clk_50mhz);
    reset_n = 1'b1;
    ptr_m = 0; last_data = 8'h00; alarm_m = 1'b0;
    push_exp(2'b11, 3, 8'h44);
    do_txn(2'b11, 3, 8'h44, 1'b0);
    e = sb.pop_front();
    checks++;
    if (!got_done || {got_v, got_d, got_to, got_al} !== e.rsp || got_lat != e.lat) begin
      errors++;
      $display("FAIL reset_mid_pointer got rsp=%h lat=%0d required rsp=%h lat=%0d",
               {got_v, got_d, got_to, got_al}, got_lat, e.rsp, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_alarm();
    test_timeout();
    test_coincident();
    test_reset_mid_wait();
    repeat (2) @(negedge clk_50mhz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_sensor_arbiter.md
# temp_sensor_arbiter

Shares the FPGA's single on-chip temperature sensor ADC between `NUM_REQ` requesters (host debug link, thermal monitor, and so on). It runs the sensor's enable/clear/wait-valid sequence once per granted request and returns the 8-bit reading, or a timeout, to that requester only. It also keeps a registered over-temperature alarm with hysteresis. It sits between the sensor IP's control/status ports and the board-level consumers.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (2..8).
- `CLEAR_CYCLES`, default 1024: cycles `temp_clear` is held high before a reading. Must be ≥ 80, the sensor ADC divider.
- `TIMEOUT_CYCLES`, default 65536: maximum cycles spent waiting for `temp_valid`.
- `ALARM_HI`, default 8'd85: alarm set threshold.
- `ALARM_LO`, default 8'd75: alarm clear threshold. Must be < `ALARM_HI`.

Ports:
- `clk_50mhz` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: level request, one bit per requester.
- `rsp_valid` out NUM_REQ: one-cycle pulse to the served requester.
- `rsp_data` out 8: reading. Valid while any `rsp_valid` bit is high.
- `rsp_timeout` out 1: qualifies `rsp_valid`. High means no reading arrived.
- `busy` out 1: high in every state except IDLE.
- `temp_valid` in 1: sensor reading valid.
- `temp_val` in 8: sensor reading.
- `temp_en` out 1: sensor enable.
- `temp_clear` out 1: sensor clear.
- `alarm` out 1: over-temperature flag.

## Operation
- The FSM has four states: IDLE, CLEAR, WAIT, DONE. Outputs are registered.
- Reset values: state IDLE, `temp_en`=0, `temp_clear`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_timeout`=0, `busy`=0, `alarm`=0, round-robin pointer=0, counter=0.
- **IDLE:** `temp_en`=0 and `temp_clear`=1. If `req` is nonzero, grant one requester by round-robin:
  - Search starts at the pointer and wraps modulo `NUM_REQ`.
  - Latch the grant index, clear the counter, go to CLEAR.
- **CLEAR:** `temp_en`=1 and `temp_clear`=1. When the counter reaches `CLEAR_CYCLES`-1, clear the counter and go to WAIT.
- **WAIT:** `temp_en`=1 and `temp_clear`=0.
  - If `temp_valid` is high, latch `temp_val` into `rsp_data`, clear the timeout flag, go to DONE.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1, set the timeout flag, keep the previous `rsp_data`, go to DONE.
  - If `temp_valid` arrives in the same cycle as the counter limit, the valid reading wins.
- **DONE (one cycle):** `rsp_valid[grant]`=1, `rsp_timeout`=flag, `temp_en`=0, `temp_clear`=1.
  - Pointer ← (grant+1) mod `NUM_REQ`.
  - Next state is IDLE.
- Requests are level-sensitive. A requester must drop `req` in the cycle after its `rsp_valid`, or it is arbitrated again and gets another reading.
- `req` bits that drop before DONE are ignored: the sequence completes and the pulse is still issued.
- Reset in mid-sequence returns to IDLE immediately. No response is issued and the sensor is disabled.
- Counter width is `$clog2(max(CLEAR_CYCLES, TIMEOUT_CYCLES))`.

## Timing
- `req` first seen high in IDLE at cycle 0:
  - `temp_en`/`busy` rise at cycle 1.
  - `temp_clear` falls at cycle `CLEAR_CYCLES`+1.
- `temp_valid` sampled at cycle t in WAIT gives `rsp_valid` high at cycle t+1 only. The next grant is possible at cycle t+2.
- A timeout gives `rsp_valid` at cycle `CLEAR_CYCLES`+`TIMEOUT_CYCLES`+1.
- `alarm` updates in the same cycle as `rsp_valid`.

## Configuration
- `TEMP_ARB_ALARM_EN` defined: alarm logic is compiled in. On each non-timeout reading, compared as unsigned values:
  - `rsp_data` ≥ `ALARM_HI` sets `alarm`.
  - `rsp_data` ≤ `ALARM_LO` clears `alarm`.
  - Otherwise `alarm` holds.
  - Timeouts do not change `alarm`.
- `TEMP_ARB_ALARM_EN` undefined: no comparator or alarm register is built, and `alarm` is tied to 0.

## Test plan
- Single request: `req`=01, sensor asserts `temp_valid` with 8'h2A five cycles into WAIT. Required: `rsp_valid`=01 for exactly one cycle, `rsp_data`=8'h2A, `rsp_timeout`=0, `temp_clear` low for exactly 6 cycles.
- Contention: `req`=11 held constantly. Required: grants alternate 0,1,0,1, and `temp_en` drops for at least one cycle between grants.
- Timeout: `temp_valid` is never asserted. Required: `rsp_valid` with `rsp_timeout`=1 at cycle `CLEAR_CYCLES`+`TIMEOUT_CYCLES`+1, `rsp_data` unchanged, `alarm` unchanged.
- Alarm hysteresis (macro defined): readings 80, 86, 80, 75, 80. Required `alarm` sequence 0,1,1,0,0. With the macro undefined, `alarm` stays 0 throughout.
- Reset mid-WAIT: `reset_n` pulsed low. Required: asynchronously `temp_en`=0, `temp_clear`=1, `busy`=0, no `rsp_valid`, and the pointer returns to requester 0.
- Coincident events: `temp_valid`=1 in the cycle the timeout limit is reached. Required: `rsp_timeout`=0 and the reading is delivered.
